// File: rtl/vdc_pkg.sv
// Shared types for the VDC VRAM slot scheduler.
//   slot_state_t : which client owns the current slot within a scanline
//   slot_tag_t   : what the slot issued last, used to route the read data that
//                  comes back one slot later
//   is_display() : true for the states that belong to the display sequence
package vdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REFRESH,
    FETCH_ATTR,
    FETCH_CHAR,
    FREE
  } slot_state_t;

  typedef enum logic [2:0] {
    NONE,
    RFSH,
    ATTR,
    CHAR,
    CPU
  } slot_tag_t;

  function automatic logic is_display(input slot_state_t s);
    return (s == REFRESH) || (s == FETCH_ATTR) || (s == FETCH_CHAR);
  endfunction

endpackage

// File: rtl/vdc_fetch_ctr.sv
// Address / column counter for one display fetch stream (attribute or char).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_load       : restart at i_base, column 0
//   i_inc        : advance address (wraps at the top of the space) and column
//   i_base       : row start address
//   i_count      : columns in the row
//   o_addr       : address for the current column
//   o_idx        : current column index
//   o_done       : all i_count columns have been issued
module vdc_fetch_ctr #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [7:0]        i_count,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_idx,
  output logic              o_done
);

  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_idx  <= '0;
    end else if (i_inc) begin
      r_addr <= r_addr + ADDR_W'(1);
      r_idx  <= r_idx + 8'd1;
    end
  end

  assign o_addr = r_addr;
  assign o_idx  = r_idx;
  assign o_done = (r_idx == i_count);

endmodule

// File: rtl/vdc_ram_sched.sv
// Per-scanline VRAM slot scheduler. Every clk with enable=1 is one VRAM slot.
// After line_start the slots go to DRAM refresh, then the attribute row, then
// the character row; the rest of the line is free for the CPU/copy port.
// Read data returns one slot after issue and is routed by a tag to either
// the fetch outputs or the CPU acknowledge.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   enable                  : slot enable
//   ram64k                  : 0 forces ram_addr[15:14] to zero (16K wrap)
//   line_start, disp_line   : scanline start pulse, line shows characters
//   reg_drr/reg_hd/reg_atr  : refresh slots, chars per row, attribute enable
//   char_base, attr_base    : row addresses, latched at line_start
//   cpu_req/we/addr/wdata   : CPU access request, held until cpu_ack
//   cpu_ack, cpu_rdata      : one-clk completion pulse with read data
//   ram_addr/we/wdata/rdata : VRAM interface
//   fetch_valid/attr/idx/data : one-clk display fetch result
//   disp_busy               : display sequence owns the slots
module vdc_ram_sched
  import vdc_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int RFSH_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              ram64k,
  input  logic              line_start,
  input  logic              disp_line,
  input  logic [3:0]        reg_drr,
  input  logic [7:0]        reg_hd,
  input  logic              reg_atr,
  input  logic [ADDR_W-1:0] char_base,
  input  logic [ADDR_W-1:0] attr_base,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              fetch_valid,
  output logic              fetch_attr,
  output logic [7:0]        fetch_idx,
  output logic [7:0]        fetch_data,
  output logic              disp_busy
);

  slot_state_t       r_state, w_eff;
  slot_tag_t         r_tag, w_tag;
  logic [3:0]        r_rfsh_left;
  logic [RFSH_W-1:0] r_rfsh_row;
  logic [7:0]        r_hd, r_tag_idx, w_idx;
  logic              r_attr_en, r_char_en;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr, w_addr_m;
  logic [ADDR_W-1:0] w_attr_addr, w_char_addr;
  logic [7:0]        w_attr_idx, w_char_idx;
  logic              w_attr_done, w_char_done;
  logic              w_rf_pend, w_at_pend, w_ch_pend;
  logic              w_slot_ls, w_attr_inc, w_char_inc;

  assign w_slot_ls  = enable & line_start;
  assign w_attr_inc = enable & ~line_start & (w_eff == FETCH_ATTR);
  assign w_char_inc = enable & ~line_start & (w_eff == FETCH_CHAR);

  vdc_fetch_ctr #(.ADDR_W(ADDR_W)) u_attr_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_slot_ls),
    .i_inc   (w_attr_inc),
    .i_base  (attr_base),
    .i_count (r_hd),
    .o_addr  (w_attr_addr),
    .o_idx   (w_attr_idx),
    .o_done  (w_attr_done)
  );

  vdc_fetch_ctr #(.ADDR_W(ADDR_W)) u_char_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_slot_ls),
    .i_inc   (w_char_inc),
    .i_base  (char_base),
    .i_count (r_hd),
    .o_addr  (w_char_addr),
    .o_idx   (w_char_idx),
    .o_done  (w_char_done)
  );

  assign w_rf_pend = (r_rfsh_left != 4'd0);
  assign w_at_pend = r_attr_en & ~w_attr_done;
  assign w_ch_pend = r_char_en & ~w_char_done;

  // Effective state for this slot: phases with nothing left to do are skipped
  // in the same slot, so the first slot after a phase ends is never wasted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_eff = r_state;
    case (r_state)
      REFRESH:    w_eff = w_rf_pend ? REFRESH
                        : w_at_pend ? FETCH_ATTR
                        : w_ch_pend ? FETCH_CHAR : FREE;
      FETCH_ATTR: w_eff = w_at_pend ? FETCH_ATTR
                        : w_ch_pend ? FETCH_CHAR : FREE;
      FETCH_CHAR: w_eff = w_ch_pend ? FETCH_CHAR : FREE;
      default:    w_eff = r_state;
    endcase
  end

  // What the slot issues. A CPU access is blocked while its own data is still
  // in flight so that at most one is ever outstanding.
  always_comb begin
    w_tag  = NONE;
    w_addr = ram_addr;
    w_idx  = '0;
    w_we   = 1'b0;
    case (w_eff)
      REFRESH: begin
        w_tag  = RFSH;
        w_addr = ADDR_W'(r_rfsh_row);
      end
      FETCH_ATTR: begin
        w_tag  = ATTR;
        w_addr = w_attr_addr;
        w_idx  = w_attr_idx;
      end
      FETCH_CHAR: begin
        w_tag  = CHAR;
        w_addr = w_char_addr;
        w_idx  = w_char_idx;
      end
      FREE: begin
        if (cpu_req && (r_tag != CPU)) begin
          w_tag  = CPU;
          w_addr = cpu_addr;
          w_we   = cpu_we;
        end
      end
      default: ;
    endcase
  end

  assign w_addr_m = ram64k ? w_addr : {2'b00, w_addr[ADDR_W-3:0]};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_tag       <= NONE;
      r_tag_idx   <= '0;
      r_rfsh_left <= '0;
      r_rfsh_row  <= '0;
      r_hd        <= '0;
      r_attr_en   <= 1'b0;
      r_char_en   <= 1'b0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      fetch_valid <= 1'b0;
      fetch_attr  <= 1'b0;
      fetch_idx   <= '0;
      fetch_data  <= '0;
      disp_busy   <= 1'b0;
    end else begin
      // Pulses last one clk, even when the next slot is several clks away.
      fetch_valid <= 1'b0;
      cpu_ack     <= 1'b0;
      if (enable) begin
        // Return path for the previous slot; runs even on a line_start slot
        // so an access already issued still completes.
        case (r_tag)
          ATTR, CHAR: begin
            fetch_valid <= 1'b1;
            fetch_attr  <= (r_tag == ATTR);
            fetch_idx   <= r_tag_idx;
            fetch_data  <= ram_rdata;
          end
          CPU: begin
            cpu_ack   <= 1'b1;
            cpu_rdata <= ram_rdata;
          end
          default: ;
        endcase
        ram_we <= 1'b0;
        r_tag  <= NONE;
        if (line_start) begin
          // The line_start slot only latches the new line's setup; refresh
          // starts on the following slot.
          r_state     <= REFRESH;
          disp_busy   <= 1'b1;
          r_rfsh_left <= reg_drr;
          r_hd        <= reg_hd;
          r_attr_en   <= disp_line & reg_atr & (reg_hd != 8'd0);
          r_char_en   <= disp_line & (reg_hd != 8'd0);
        end else begin
          r_state   <= w_eff;
          disp_busy <= is_display(w_eff);
          if (w_tag != NONE) begin
            ram_addr  <= w_addr_m;
            ram_we    <= w_we;
            r_tag     <= w_tag;
            r_tag_idx <= w_idx;
          end
          if (w_tag == CPU) ram_wdata <= cpu_wdata;
          if (w_tag == RFSH) begin
            r_rfsh_row  <= r_rfsh_row + RFSH_W'(1);
            r_rfsh_left <= r_rfsh_left - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vdc_ram_sched.sv
// Self-checking bench for vdc_ram_sched. A line model turns the latched line
// setup into the list of slots it must produce; every slot is compared for
// the issued address/strobe and for the data pulse of the slot before it.
module tb_vdc_ram_sched;

  localparam int K_NONE = 0;
  localparam int K_RFSH = 1;
  localparam int K_ATTR = 2;
  localparam int K_CHAR = 3;
  localparam int K_CPU  = 4;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    int          idx;
    bit          we;
    logic [7:0]  wdata;
    bit          ls;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable, ram64k, line_start, disp_line, reg_atr;
  logic [3:0]  reg_drr;
  logic [7:0]  reg_hd;
  logic [15:0] char_base, attr_base;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        fetch_valid, fetch_attr;
  logic [7:0]  fetch_idx, fetch_data;
  logic        disp_busy;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          gap_max  = 0;
  exp_t        pend;
  exp_t        exp_q[$];
  logic [15:0] last_addr;
  logic [7:0]  rfsh_row_m;

  vdc_ram_sched dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .ram64k      (ram64k),
    .line_start  (line_start),
    .disp_line   (disp_line),
    .reg_drr     (reg_drr),
    .reg_hd      (reg_hd),
    .reg_atr     (reg_atr),
    .char_base   (char_base),
    .attr_base   (attr_base),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .fetch_valid (fetch_valid),
    .fetch_attr  (fetch_attr),
    .fetch_idx   (fetch_idx),
    .fetch_data  (fetch_data),
    .disp_busy   (disp_busy)
  );

  always #5 clk = ~clk;

  // VRAM: read data follows the registered address, writes land on the slot
  // edge that ends the write strobe.
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (enable && ram_we) mem[ram_addr] <= ram_wdata;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t mk(input int kind, input logic [15:0] addr, input int idx,
                              input bit we, input logic [7:0] wd, input bit ls);
    exp_t e;
    e.kind = kind; e.addr = addr; e.idx = idx; e.we = we; e.wdata = wd; e.ls = ls;
    return e;
  endfunction

  function automatic logic [15:0] amask(input logic [15:0] a);
    logic [15:0] r;
    r = a;
    if (!ram64k) r[15:14] = 2'b00;
    return r;
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_RFSH:  return "issue_rfsh";
      K_ATTR:  return "issue_attr";
      K_CHAR:  return "issue_char";
      K_CPU:   return "issue_cpu";
      default: return "issue";
    endcase
  endfunction

  // One slot: pulse the enable, check the data returned for the previous
  // slot and what this slot issued, then idle a few random clks.
  task automatic slot_check(input exp_t e);
    int n_gap;
    bit busy;
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    case (pend.kind)
      K_ATTR, K_CHAR:
        check($sformatf("fetch_%0d", pend.idx),
              {cpu_ack, fetch_valid, fetch_attr, fetch_idx, fetch_data},
              {1'b0, 1'b1, (pend.kind == K_ATTR), pend.idx[7:0], ref_mem[pend.addr]});
      K_CPU: begin
        check("cpu_ack", {fetch_valid, cpu_ack}, 2'b01);
        if (!pend.we) check("cpu_rdata", cpu_rdata, ref_mem[pend.addr]);
        else ref_mem[pend.addr] = pend.wdata;
      end
      default: check("no_pulse", {fetch_valid, cpu_ack}, 2'b00);
    endcase
    busy = e.ls || (e.kind inside {K_RFSH, K_ATTR, K_CHAR});
    if (e.kind == K_NONE) begin
      check("idle", {disp_busy, ram_we, ram_addr}, {busy, 1'b0, last_addr});
    end else begin
      check(kname(e.kind), {disp_busy, ram_we, ram_addr}, {busy, e.we, e.addr});
      last_addr = e.addr;
      if (e.we) check("wdata", ram_wdata, e.wdata);
    end
    pend = e;
    n_gap = int'($urandom_range(0, gap_max));
    for (int g = 0; g < n_gap; g++) begin
      @(posedge clk);
      #1;
      if (g == 0) check("pulse_1clk", {fetch_valid, cpu_ack}, 2'b00);
    end
  endtask

  task automatic idle_slot();
    slot_check(mk(K_NONE, 16'h0, 0, 1'b0, 8'h0, 1'b0));
  endtask

  // Line start slot, then the model's slot list for the line just latched.
  task automatic line_start_slot();
    line_start = 1'b1;
    slot_check(mk(K_NONE, 16'h0, 0, 1'b0, 8'h0, 1'b1));
    line_start = 1'b0;
    for (int i = 0; i < int'(reg_drr); i++) begin
      exp_q.push_back(mk(K_RFSH, {8'h00, rfsh_row_m}, 0, 1'b0, 8'h0, 1'b0));
      rfsh_row_m = rfsh_row_m + 8'd1;
    end
    if (disp_line && reg_atr && reg_hd != 0)
      for (int i = 0; i < int'(reg_hd); i++)
        exp_q.push_back(mk(K_ATTR, amask(attr_base + 16'(i)), i, 1'b0, 8'h0, 1'b0));
    if (disp_line && reg_hd != 0)
      for (int i = 0; i < int'(reg_hd); i++)
        exp_q.push_back(mk(K_CHAR, amask(char_base + 16'(i)), i, 1'b0, 8'h0, 1'b0));
  endtask

  // Play the expected slots; when abort_col is reached in the char row a new
  // line_start is given instead of that slot.
  task automatic run_q(input int abort_col);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q[0];
      if (abort_col >= 0 && e.kind == K_CHAR && e.idx == abort_col) begin
        exp_q.delete();
        line_start_slot();
        return;
      end
      void'(exp_q.pop_front());
      slot_check(e);
    end
  endtask

  task automatic cpu_access(input bit we, input logic [15:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    slot_check(mk(K_CPU, amask(a), 0, we, d, 1'b0));
    idle_slot();
    cpu_req = 1'b0;
  endtask

  task automatic set_line(input int drr, input int hd, input bit atr, input bit disp,
                          input logic [15:0] ab, input logic [15:0] cb);
    reg_drr = 4'(drr); reg_hd = 8'(hd); reg_atr = atr; disp_line = disp;
    attr_base = ab; char_base = cb;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    reset_n = 1'b0; enable = 1'b0; ram64k = 1'b1; line_start = 1'b0;
    set_line(0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    pend = mk(K_NONE, 16'h0, 0, 1'b0, 8'h0, 1'b0);
    last_addr = '0; rfsh_row_m = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata, fetch_valid,
                            fetch_attr, fetch_idx, fetch_data, disp_busy}, 64'h0);
    reset_n = 1'b1;

    // IDLE: a CPU request must not be served before the first line.
    cpu_req = 1'b1; cpu_addr = 16'h0100;
    idle_slot();
    idle_slot();
    cpu_req = 1'b0;

    // Full display line with random slot spacing.
    gap_max = 2;
    set_line(5, 80, 1'b1, 1'b1, 16'($urandom), 16'($urandom));
    line_start_slot();
    run_q(-1);
    idle_slot();
    gap_max = 0;

    // Empty line: CPU request raised with line_start waits one slot.
    set_line(0, 0, 1'b0, 1'b1, 16'h0, 16'h0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    line_start_slot();
    run_q(-1);
    slot_check(mk(K_CPU, 16'h1234, 0, 1'b0, 8'h0, 1'b0));
    idle_slot();
    cpu_req = 1'b0;
    idle_slot();

    // CPU write held off by the display sequence, then read back.
    set_line(2, 6, 1'b0, 1'b1, 16'h0, 16'h0800);
    line_start_slot();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2345; cpu_wdata = 8'hA5;
    run_q(-1);
    slot_check(mk(K_CPU, 16'h2345, 0, 1'b1, 8'hA5, 1'b0));
    idle_slot();
    cpu_req = 1'b0;
    idle_slot();
    cpu_access(1'b0, 16'h2345, 8'h00);

    // Address wrap at the top of memory, then with the 16K mask.
    set_line(0, 4, 1'b0, 1'b1, 16'h0, 16'hFFFE);
    line_start_slot();
    run_q(-1);
    idle_slot();
    ram64k = 1'b0;
    line_start_slot();
    run_q(-1);
    idle_slot();
    ram64k = 1'b1;

    // New line_start in the middle of the char row.
    set_line(3, 80, 1'b1, 1'b1, 16'($urandom), 16'($urandom));
    line_start_slot();
    run_q(40);
    run_q(-1);
    idle_slot();

    // Random lines; setup inputs change mid-line and must not take effect.
    gap_max = 1;
    for (int n = 0; n < 6; n++) begin
      ram64k = 1'($urandom);
      set_line(int'($urandom_range(0, 15)), int'($urandom_range(0, 12)), 1'($urandom),
               1'($urandom), 16'($urandom), 16'($urandom));
      line_start_slot();
      set_line(int'($urandom_range(0, 15)), int'($urandom_range(0, 12)), 1'($urandom),
               1'($urandom), 16'($urandom), 16'($urandom));
      run_q(-1);
      cpu_access(1'($urandom), 16'($urandom), 8'($urandom));
      idle_slot();
    end
    gap_max = 0;
    ram64k = 1'b1;

    // Reset in the middle of a CPU read.
    set_line(0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    line_start_slot();
    run_q(-1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4321;
    slot_check(mk(K_CPU, 16'h4321, 0, 1'b0, 8'h0, 1'b0));
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_access", {cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata, fetch_valid,
                               fetch_attr, fetch_idx, fetch_data, disp_busy}, 64'h0);
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    enable = 1'b0;
    reset_n = 1'b1;
    pend = mk(K_NONE, 16'h0, 0, 1'b0, 8'h0, 1'b0);
    last_addr = '0;
    rfsh_row_m = '0;
    idle_slot();
    cpu_req = 1'b0;
    set_line(3, 2, 1'b0, 1'b1, 16'h0, 16'h0100);
    line_start_slot();
    run_q(-1);
    idle_slot();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
